// File: rtl/alarm_pkg.sv
// Shared state encodings, parameter defaults and counter sizing for the alarm responder.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_QUALIFY  = 2'd1,
        ST_ALARM    = 2'd2,
        ST_SILENCED = 2'd3
    } state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned BEEP_PERIOD_DEF     = 8;
    localparam int unsigned SILENCE_CYCLES_DEF  = 32;
    localparam int unsigned CNT_W_DEF           = 8;

    // Width able to hold the value n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// Square-wave generator: high on restart, toggles every BEEP_PERIOD cycles, low while disabled.
module alarm_tone_gen
    import alarm_pkg::*;
#(
    parameter int unsigned BEEP_PERIOD = BEEP_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic tone
);

    localparam int unsigned PW = cnt_width(BEEP_PERIOD);

    logic [PW-1:0] per_cnt_q, per_cnt_d;
    logic          tone_q, tone_d;

    always_comb begin
        per_cnt_d = per_cnt_q;
        tone_d    = tone_q;
        if (!en) begin
            per_cnt_d = '0;
            tone_d    = 1'b0;
        end else if (restart) begin
            per_cnt_d = '0;
            tone_d    = 1'b1;
        end else if (per_cnt_q == PW'(BEEP_PERIOD - 1)) begin
            per_cnt_d = '0;
            tone_d    = ~tone_q;
        end else begin
            per_cnt_d = per_cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_cnt_q <= '0;
            tone_q    <= 1'b0;
        end else begin
            per_cnt_q <= per_cnt_d;
            tone_q    <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/alarm_responder.sv
// Debounces the alarm request, latches it until acknowledged, annunciates via buzzer/LED
// and keeps a saturating count of qualified alarm events.
module alarm_responder
    import alarm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned BEEP_PERIOD     = BEEP_PERIOD_DEF,
    parameter int unsigned SILENCE_CYCLES  = SILENCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    input  logic             ack,
    input  logic             cnt_clr,
    output logic             alarm_active,
    output logic             buzzer,
    output logic             led,
    output logic             ack_done,
    output logic [CNT_W-1:0] event_count
);

    localparam int unsigned QW = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned SW = cnt_width(SILENCE_CYCLES);

    state_e            state_q, state_d;
    logic [QW-1:0]     qual_cnt_q, qual_cnt_d;
    logic [SW-1:0]     sil_cnt_q, sil_cnt_d;
    logic [CNT_W-1:0]  event_count_q, event_count_d;
    logic              alarm_active_q, alarm_active_d;
    logic              ack_done_q, ack_done_d;
    logic              count_inc;
    logic              buz_en_c, buz_restart_c;
    logic              led_en_c, led_restart_c;

    // Next-state and counter logic.
    always_comb begin
        state_d    = state_q;
        qual_cnt_d = qual_cnt_q;
        sil_cnt_d  = sil_cnt_q;
        count_inc  = 1'b0;
        ack_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                qual_cnt_d = '0;
                if (A) begin
                    if (DEBOUNCE_CYCLES <= 1) begin
                        state_d   = ST_ALARM;
                        count_inc = 1'b1;
                    end else begin
                        state_d    = ST_QUALIFY;
                        qual_cnt_d = QW'(1);
                    end
                end
            end
            ST_QUALIFY: begin
                if (!A) begin
                    state_d    = ST_IDLE;
                    qual_cnt_d = '0;
                end else if (qual_cnt_q == QW'(DEBOUNCE_CYCLES - 1)) begin
                    state_d    = ST_ALARM;
                    qual_cnt_d = '0;
                    count_inc  = 1'b1;
                end else begin
                    qual_cnt_d = qual_cnt_q + QW'(1);
                end
            end
            ST_ALARM: begin
                if (ack) begin
                    state_d    = ST_SILENCED;
                    sil_cnt_d  = '0;
                    ack_done_d = 1'b1;
                end
            end
            ST_SILENCED: begin
                // Dropped request takes priority over re-sounding on expiry.
                if (!A) begin
                    state_d   = ST_IDLE;
                    sil_cnt_d = '0;
                end else if (sil_cnt_q == SW'(SILENCE_CYCLES - 1)) begin
                    state_d   = ST_ALARM;
                    sil_cnt_d = '0;
                end else begin
                    sil_cnt_d = sil_cnt_q + SW'(1);
                end
            end
        endcase

        event_count_d = event_count_q;
        if (cnt_clr) begin
            event_count_d = '0;
        end else if (count_inc && (event_count_q != {CNT_W{1'b1}})) begin
            event_count_d = event_count_q + CNT_W'(1);
        end

        alarm_active_d = (state_d == ST_ALARM) || (state_d == ST_SILENCED);

        buz_en_c      = (state_d == ST_ALARM);
        buz_restart_c = buz_en_c && (state_q != ST_ALARM);
        // Holding restart throughout ALARM keeps the LED steady; blinking starts on silence entry.
        led_en_c      = alarm_active_d;
        led_restart_c = (state_d == ST_ALARM) ||
                        ((state_d == ST_SILENCED) && (state_q != ST_SILENCED));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            qual_cnt_q     <= '0;
            sil_cnt_q      <= '0;
            event_count_q  <= '0;
            alarm_active_q <= 1'b0;
            ack_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            qual_cnt_q     <= qual_cnt_d;
            sil_cnt_q      <= sil_cnt_d;
            event_count_q  <= event_count_d;
            alarm_active_q <= alarm_active_d;
            ack_done_q     <= ack_done_d;
        end
    end

    alarm_tone_gen #(
        .BEEP_PERIOD(BEEP_PERIOD)
    ) u_buzzer_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (buz_en_c),
        .restart(buz_restart_c),
        .tone   (buzzer)
    );

    alarm_tone_gen #(
        .BEEP_PERIOD(BEEP_PERIOD)
    ) u_led_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (led_en_c),
        .restart(led_restart_c),
        .tone   (led)
    );

    assign alarm_active = alarm_active_q;
    assign ack_done     = ack_done_q;
    assign event_count  = event_count_q;

endmodule
